filter_seq_ctrl: RTL and testbench
==================================

// Module: filter_seq_ctrl
// PURPOSE
//  Run-time sequencer for the shaping filter on one ADC channel. Accepts a k/l/M/threshold config, flushes the filter, waits out its settle time, then arms.
//  Once armed it finds pulses above threshold on the filter output and emits peak amplitudes through a valid/ready event port.
//  Sits between the config register bank and the readout FIFO.
// PARAMETERS
//  KW        5    width of cfg_k / cfg_l (filter delay lengths)
//  MW        8    width of cfg_m (pole-zero multiplier)
//  PIPE_LAT  6    filter pipeline depth from ADC sample to output_data, in cycles
//  FLUSH_CYC 4    cycles flt_reset_n is held low on each config load (>=1)
//  DROPW     16   width of drop counter
// PORTS
//  clk          in   1                 system clock
//  reset        in   1                 asynchronous, active-low reset
//  cfg_valid    in   1                 config word offered
//  cfg_ready    out  1                 config accepted this cycle when cfg_valid&cfg_ready
//  cfg_k        in   KW                filter k
//  cfg_l        in   KW                filter l
//  cfg_m        in   MW                filter M
//  cfg_thr      in   SIZE_FILTER_DATA  trigger threshold (unsigned)
//  stop         in   1                 return to IDLE; filter held in reset
//  flt_reset_n  out  1                 drives the filter's active-low reset
//  flt_k        out  KW                registered k to filter
//  flt_l        out  KW                registered l to filter
//  flt_m        out  MW                registered M to filter
//  flt_data     in   SIZE_FILTER_DATA  filter output_data
//  evt_valid    out  1                 event available
//  evt_ready    in   1                 downstream takes event
//  evt_amp      out  SIZE_FILTER_DATA  peak amplitude
//  evt_time     out  32                peak timestamp (FILTER_SEQ_TIMESTAMP_EN only)
//  armed        out  1                 state is ARMED or PEAK
//  drop_cnt     out  DROPW             events lost to back-pressure, saturating
// BEHAVIOUR
//  Reset values: state=IDLE, flt_reset_n=0, flt_k/l/m=0, evt_valid=0, evt_amp=0, evt_time=0, drop_cnt=0, armed=0. cfg_ready is 1 after reset.
//  All outputs are registered. cfg_ready=1 in IDLE and ARMED; 0 in FLUSH, SETTLE, PEAK.
//  IDLE:   flt_reset_n=0. On a cfg handshake, latch k/l/m/thr and go to FLUSH.
//  FLUSH:  flt_reset_n=0 for exactly FLUSH_CYC cycles, then SETTLE.
//  SETTLE: flt_reset_n=1. Count cfg_k+cfg_l+PIPE_LAT cycles (computed at KW+4 bits, no overflow); flt_data is ignored. Then ARMED.
//  ARMED:  if flt_data > thr (strict), set max<=flt_data, capture the timestamp, go to PEAK.
//          A cfg handshake in ARMED goes to FLUSH (reconfigure).
//  PEAK:   if flt_data > max, update max and timestamp (first maximum wins on equal values).
//          When flt_data <= thr the pulse is complete; go to ARMED.
//  Emit on completion:
//          - slot free (evt_valid=0, or evt_valid&evt_ready this cycle): load evt_amp=max and evt_time, set evt_valid=1 next cycle.
//          - slot busy: drop the event; drop_cnt+1, saturating at all-ones.
//  Handshake: evt_valid stays high and evt_amp/evt_time stay stable until evt_ready. A transfer and a new load in the same cycle keep evt_valid=1 with the new data.
//  stop: highest priority, from any state go to IDLE next cycle and abandon an open peak. A pending evt_valid is kept until it is taken.
//  Reconfig (FLUSH entry) also keeps a pending event. drop_cnt is cleared only by reset.
// CONFIGURATION
//  `FILTER_SEQ_TIMESTAMP_EN defined:
//   - a 32-bit free-running cycle counter, cleared by reset and wrapping at 2^32;
//   - evt_time port present; it holds the counter value at the cycle max was last updated.
//  Undefined: no counter, no evt_time port; all other behaviour identical.
// STRUCTURE
//  package_settings holds SIZE_FILTER_DATA and SIZE_ADC_DATA, plus the new typedef enum logic [2:0] {IDLE,FLUSH,SETTLE,ARMED,PEAK} seq_state_t.
//  Default constants PIPE_LAT and FLUSH_CYC also go in the package.
//  One sub-module, filter_peak_tracker: holds max and timestamp, drives the above-threshold compare, and pulses done on pulse completion.
//  The FSM, counters and event slot stay in filter_seq_ctrl.
// TESTING
//  1 Reset, cfg k=4 l=8 m=10 thr=100: flt_reset_n low for 4 cycles, then armed rises exactly 4+8+6=18 cycles later.
//  2 Armed, flt_data ramp 50,120,300,250,90: after the 90 sample, evt_valid=1 with evt_amp=300. Values above 100 during SETTLE make no event.
//  3 evt_ready=0, two pulses (peaks 300 and 500): evt_amp stays 300, drop_cnt=1. With evt_ready=1 on the 2nd completion cycle, evt_amp=500 and drop_cnt=0.
//  4 stop asserted mid-PEAK: IDLE next cycle, flt_reset_n=0, no event produced, cfg_ready=1.
//  5 cfg handshake in ARMED with a pending event: FLUSH entered, event retained until evt_ready.
//  6 Plateau 400,400,400 then 0, timestamp enabled: evt_amp=400, evt_time = counter at the first 400 sample.

Source files
------------

// File: rtl/package_settings.sv
// Shared widths, default sequencer timing and the sequencer state type
// for the shaping-filter channel.
package package_settings;

  localparam int unsigned SIZE_FILTER_DATA = 16;
  localparam int unsigned SIZE_ADC_DATA    = 14;
  localparam int unsigned DEF_PIPE_LAT     = 6;
  localparam int unsigned DEF_FLUSH_CYC    = 4;
  localparam int unsigned TS_W             = 32;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SETTLE,
    ARMED,
    PEAK
  } seq_state_t;

endpackage : package_settings

// File: rtl/filter_peak_tracker.sv
// Tracks the running maximum (and optionally its timestamp) of one pulse on the
// filter output. Timestamp capture is built only with FILTER_SEQ_TIMESTAMP_EN.
module filter_peak_tracker
  import package_settings::*;
#(
  parameter int unsigned DW = SIZE_FILTER_DATA
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm_i,
  input  logic          track_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] thr_i,
`ifdef FILTER_SEQ_TIMESTAMP_EN
  input  logic [TS_W-1:0] ts_i,
  output logic [TS_W-1:0] ts_o,
`endif
  output logic          above_c_o,
  output logic          done_c_o,
  output logic [DW-1:0] max_o
);

  logic [DW-1:0] max_q, max_d;
  logic          upd;
`ifdef FILTER_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
`endif

  // Strict compares: equal samples never restart or move the peak.
  always_comb begin
    above_c_o = (data_i > thr_i);
    done_c_o  = track_i & ~above_c_o;
    upd       = (arm_i & above_c_o) | (track_i & (data_i > max_q));
    max_d     = max_q;
`ifdef FILTER_SEQ_TIMESTAMP_EN
    ts_d      = ts_q;
`endif
    if (upd) begin
      max_d = data_i;
`ifdef FILTER_SEQ_TIMESTAMP_EN
      ts_d  = ts_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
`ifdef FILTER_SEQ_TIMESTAMP_EN
      ts_q  <= '0;
`endif
    end else begin
      max_q <= max_d;
`ifdef FILTER_SEQ_TIMESTAMP_EN
      ts_q  <= ts_d;
`endif
    end
  end

  assign max_o = max_q;
`ifdef FILTER_SEQ_TIMESTAMP_EN
  assign ts_o  = ts_q;
`endif

endmodule : filter_peak_tracker

// File: rtl/filter_seq_ctrl.sv
// Run-time sequencer for one shaping-filter channel: config load, flush, settle,
// pulse peak detection and a one-deep event slot. FILTER_SEQ_TIMESTAMP_EN adds evt_time.
module filter_seq_ctrl
  import package_settings::*;
#(
  parameter int unsigned KW        = 5,
  parameter int unsigned MW        = 8,
  parameter int unsigned PIPE_LAT  = DEF_PIPE_LAT,
  parameter int unsigned FLUSH_CYC = DEF_FLUSH_CYC,
  parameter int unsigned DROPW     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [KW-1:0]               cfg_k,
  input  logic [KW-1:0]               cfg_l,
  input  logic [MW-1:0]               cfg_m,
  input  logic [SIZE_FILTER_DATA-1:0] cfg_thr,
  input  logic                        stop,
  output logic                        flt_reset_n,
  output logic [KW-1:0]               flt_k,
  output logic [KW-1:0]               flt_l,
  output logic [MW-1:0]               flt_m,
  input  logic [SIZE_FILTER_DATA-1:0] flt_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [SIZE_FILTER_DATA-1:0] evt_amp,
`ifdef FILTER_SEQ_TIMESTAMP_EN
  output logic [TS_W-1:0]             evt_time,
`endif
  output logic                        armed,
  output logic [DROPW-1:0]            drop_cnt
);

  localparam int unsigned DW = SIZE_FILTER_DATA;
  localparam int unsigned SW = KW + 4;
  localparam int unsigned FW = $clog2(FLUSH_CYC + 1);
  localparam int unsigned CW = (SW > FW) ? SW : FW;

  seq_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d, l_q, l_d;
  logic [MW-1:0]  m_q, m_d;
  logic [DW-1:0]  thr_q, thr_d;
  logic           cfg_ready_q, cfg_ready_d;
  logic           flt_rst_n_q, flt_rst_n_d;
  logic           armed_q, armed_d;
  logic           evt_valid_q, evt_valid_d;
  logic [DW-1:0]  evt_amp_q, evt_amp_d;
  logic [DROPW-1:0] drop_q, drop_d;
  logic [SW-1:0]  settle_len;
  logic           cfg_hs, ld_cfg, done_ev, slot_free;
  logic           pk_above, pk_done;
  logic [DW-1:0]  pk_max;
`ifdef FILTER_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, evt_time_q, evt_time_d, pk_ts;
`endif

  filter_peak_tracker #(.DW(DW)) u_peak (
    .clk       (clk),
    .reset     (reset),
    .arm_i     (state_q == ARMED),
    .track_i   (state_q == PEAK),
    .data_i    (flt_data),
    .thr_i     (thr_q),
`ifdef FILTER_SEQ_TIMESTAMP_EN
    .ts_i      (ts_q),
    .ts_o      (pk_ts),
`endif
    .above_c_o (pk_above),
    .done_c_o  (pk_done),
    .max_o     (pk_max)
  );

  // Next state, counters, latched config and event slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    l_d         = l_q;
    m_d         = m_q;
    thr_d       = thr_q;
    evt_valid_d = evt_valid_q & ~evt_ready;
    evt_amp_d   = evt_amp_q;
    drop_d      = drop_q;
    ld_cfg      = 1'b0;
    cfg_hs      = cfg_valid & cfg_ready_q;
    settle_len  = SW'(k_q) + SW'(l_q) + SW'(PIPE_LAT);
    done_ev     = pk_done & ~stop & (state_q == PEAK);
    slot_free   = ~evt_valid_q | evt_ready;
`ifdef FILTER_SEQ_TIMESTAMP_EN
    ts_d        = ts_q + TS_W'(1);
    evt_time_d  = evt_time_q;
`endif

    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_hs) ld_cfg = 1'b1;
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_d = SETTLE;
            cnt_d   = CW'(settle_len);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        // A zero settle length still spends one cycle here.
        SETTLE: begin
          if (cnt_q <= CW'(1)) state_d = ARMED;
          else                 cnt_d   = cnt_q - CW'(1);
        end
        ARMED: begin
          if (cfg_hs)        ld_cfg  = 1'b1;
          else if (pk_above) state_d = PEAK;
        end
        PEAK: begin
          if (pk_done) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end

    if (ld_cfg) begin
      state_d = FLUSH;
      cnt_d   = CW'(FLUSH_CYC - 1);
      k_d     = cfg_k;
      l_d     = cfg_l;
      m_d     = cfg_m;
      thr_d   = cfg_thr;
    end

    // Completed pulse either fills the slot or is counted as dropped.
    if (done_ev) begin
      if (slot_free) begin
        evt_valid_d = 1'b1;
        evt_amp_d   = pk_max;
`ifdef FILTER_SEQ_TIMESTAMP_EN
        evt_time_d  = pk_ts;
`endif
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROPW'(1);
      end
    end

    cfg_ready_d = (state_d == IDLE) || (state_d == ARMED);
    flt_rst_n_d = (state_d != IDLE) && (state_d != FLUSH);
    armed_d     = (state_d == ARMED) || (state_d == PEAK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      l_q         <= '0;
      m_q         <= '0;
      thr_q       <= '0;
      cfg_ready_q <= 1'b1;
      flt_rst_n_q <= 1'b0;
      armed_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_amp_q   <= '0;
      drop_q      <= '0;
`ifdef FILTER_SEQ_TIMESTAMP_EN
      ts_q        <= '0;
      evt_time_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      l_q         <= l_d;
      m_q         <= m_d;
      thr_q       <= thr_d;
      cfg_ready_q <= cfg_ready_d;
      flt_rst_n_q <= flt_rst_n_d;
      armed_q     <= armed_d;
      evt_valid_q <= evt_valid_d;
      evt_amp_q   <= evt_amp_d;
      drop_q      <= drop_d;
`ifdef FILTER_SEQ_TIMESTAMP_EN
      ts_q        <= ts_d;
      evt_time_q  <= evt_time_d;
`endif
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign flt_reset_n = flt_rst_n_q;
  assign flt_k       = k_q;
  assign flt_l       = l_q;
  assign flt_m       = m_q;
  assign evt_valid   = evt_valid_q;
  assign evt_amp     = evt_amp_q;
  assign armed       = armed_q;
  assign drop_cnt    = drop_q;
`ifdef FILTER_SEQ_TIMESTAMP_EN
  assign evt_time    = evt_time_q;
`endif

endmodule : filter_seq_ctrl

// File: tb/tb_filter_seq_ctrl.sv
// Directed plus random stimulus for filter_seq_ctrl against a pulse-level
// reference model; evt_time is checked when FILTER_SEQ_TIMESTAMP_EN is defined.
module tb_filter_seq_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned KW = 5;
  localparam int unsigned MW = 8;
  localparam int unsigned PIPE = 6;
  localparam int unsigned FLUSH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [KW-1:0] cfg_k = '0, cfg_l = '0;
  logic [MW-1:0] cfg_m = '0;
  logic [DW-1:0] cfg_thr = '0;
  logic          stop = 1'b0;
  logic          flt_reset_n;
  logic [KW-1:0] flt_k, flt_l;
  logic [MW-1:0] flt_m;
  logic [DW-1:0] flt_data = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [DW-1:0] evt_amp;
  logic [31:0]   evt_time;
  logic          armed;
  logic [15:0]   drop_cnt;

  int unsigned ntot = 0, npass = 0, nfail = 0;

  // Reference: cycle counter, pulse state and one-deep event slot.
  logic [31:0] tb_ts;
  bit          m_armed, m_inp, m_pv;
  logic [DW-1:0] m_thr, m_max, m_amp;
  logic [31:0] m_t, m_time;
  int unsigned m_drop;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;

  filter_seq_ctrl dut (
    .clk         (clk),
    .reset       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_k       (cfg_k),
    .cfg_l       (cfg_l),
    .cfg_m       (cfg_m),
    .cfg_thr     (cfg_thr),
    .stop        (stop),
    .flt_reset_n (flt_reset_n),
    .flt_k       (flt_k),
    .flt_l       (flt_l),
    .flt_m       (flt_m),
    .flt_data    (flt_data),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_amp     (evt_amp),
`ifdef FILTER_SEQ_TIMESTAMP_EN
    .evt_time    (evt_time),
`endif
    .armed       (armed),
    .drop_cnt    (drop_cnt)
  );

`ifndef FILTER_SEQ_TIMESTAMP_EN
  assign evt_time = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(m_pv));
    chk({tag, ".evt_amp"}, 32'(evt_amp), 32'(m_amp));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), m_drop);
    chk({tag, ".armed"}, 32'(armed), 32'(m_armed));
`ifdef FILTER_SEQ_TIMESTAMP_EN
    chk({tag, ".evt_time"}, evt_time, m_time);
`endif
  endtask

  // One armed-phase cycle: predict from the pulse rules, clock, compare.
  task automatic step(input logic [DW-1:0] d, input bit rdy);
    bit done, free;
    flt_data  = d;
    evt_ready = rdy;
    done = 1'b0;
    free = !m_pv || rdy;
    if (m_armed) begin
      if (!m_inp) begin
        if (d > m_thr) begin m_inp = 1'b1; m_max = d; m_t = tb_ts; end
      end else if (d > m_max) begin
        m_max = d; m_t = tb_ts;
      end else if (d <= m_thr) begin
        m_inp = 1'b0; done = 1'b1;
      end
    end
    if (done && free) begin
      m_pv = 1'b1; m_amp = m_max; m_time = m_t;
    end else begin
      if (done && m_drop != 32'd65535) m_drop++;
      if (rdy) m_pv = 1'b0;
    end
    @(posedge clk); #1;
    check_outs("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; stop = 1'b0; flt_data = '0; evt_ready = 1'b0;
    m_armed = 0; m_inp = 0; m_pv = 0; m_amp = '0; m_time = '0; m_drop = 0;
    m_thr = '0; m_max = '0; m_t = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst.flt_reset_n", 32'(flt_reset_n), 32'd0);
    chk("rst.flt_k", 32'(flt_k), 32'd0);
    chk("rst.flt_m", 32'(flt_m), 32'd0);
    check_outs("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Config handshake, then measure flush and settle lengths.
  task automatic configure(input int unsigned k, input int unsigned l, input int unsigned m,
                           input int unsigned thr, input bit junk);
    int n;
    evt_ready = 1'b0;
    flt_data  = '0;
    cfg_k = KW'(k); cfg_l = KW'(l); cfg_m = MW'(m); cfg_thr = DW'(thr);
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("cfg.ready_wait", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_armed = 1'b0; m_inp = 1'b0; m_thr = DW'(thr);
    chk("cfg.flt_k", 32'(flt_k), k);
    chk("cfg.flt_l", 32'(flt_l), l);
    chk("cfg.flt_m", 32'(flt_m), m);
    chk("cfg.ready_low", 32'(cfg_ready), 32'd0);
    chk("cfg.armed_low", 32'(armed), 32'd0);
    n = 0;
    while (!flt_reset_n && n < 100) begin @(posedge clk); #1; n++; end
    chk("cfg.flush_cycles", 32'(n), FLUSH);
    n = 0;
    while (!armed && n < 200) begin
      flt_data = junk ? DW'(500) : DW'(0);
      @(posedge clk); #1; n++;
    end
    chk("cfg.settle_cycles", 32'(n), k + l + PIPE);
    flt_data = '0;
    m_armed = 1'b1;
    check_outs("cfg.end");
  endtask

  initial begin
    logic [31:0] t_first;
    int unsigned rk, rl, rthr, r;
    logic [DW-1:0] d;

    // Reset, bring-up timing, samples above threshold while settling.
    do_reset();
    configure(4, 8, 10, 100, 1'b1);

    // Ramp pulse.
    step(50, 0); step(120, 0); step(300, 0); step(250, 0); step(90, 0);
    chk("ramp.valid", 32'(evt_valid), 32'd1);
    chk("ramp.amp", 32'(evt_amp), 32'd300);

    // Second pulse while the slot is blocked is dropped.
    step(0, 0); step(150, 0); step(500, 0); step(0, 0);
    chk("bp.amp_kept", 32'(evt_amp), 32'd300);
    chk("bp.drop", 32'(drop_cnt), 32'd1);
    step(0, 1);

    // Transfer and reload in the same cycle.
    do_reset();
    configure(4, 8, 10, 100, 1'b0);
    step(300, 0); step(0, 0); step(500, 0); step(0, 1);
    chk("xfer.valid", 32'(evt_valid), 32'd1);
    chk("xfer.amp", 32'(evt_amp), 32'd500);
    chk("xfer.drop", 32'(drop_cnt), 32'd0);
    step(0, 1);

    // Stop in the middle of a pulse.
    step(200, 0); step(300, 0);
    stop = 1'b1; flt_data = 50;
    m_armed = 1'b0; m_inp = 1'b0;
    @(posedge clk); #1;
    chk("stop.armed", 32'(armed), 32'd0);
    chk("stop.flt_reset_n", 32'(flt_reset_n), 32'd0);
    chk("stop.cfg_ready", 32'(cfg_ready), 32'd1);
    check_outs("stop");
    stop = 1'b0;
    step(0, 0); step(0, 0);

    // Reconfigure from ARMED with an event pending.
    configure(3, 5, 7, 100, 1'b0);
    step(200, 0); step(0, 0);
    chk("recfg.pending", 32'(evt_valid), 32'd1);
    configure(2, 2, 9, 80, 1'b0);
    chk("recfg.kept_valid", 32'(evt_valid), 32'd1);
    chk("recfg.kept_amp", 32'(evt_amp), 32'd200);
    step(0, 1);
    chk("recfg.taken", 32'(evt_valid), 32'd0);

    // Plateau: first maximum keeps its timestamp.
    t_first = tb_ts;
    step(400, 0); step(400, 0); step(400, 0); step(0, 0);
    chk("plateau.amp", 32'(evt_amp), 32'd400);
`ifdef FILTER_SEQ_TIMESTAMP_EN
    chk("plateau.time", evt_time, t_first);
`endif
    step(0, 1);

    // Random traffic with one mid-run reconfiguration.
    rk = $urandom_range(0, 31); rl = $urandom_range(0, 31); rthr = $urandom_range(50, 300);
    configure(rk, rl, $urandom_range(0, 255), rthr, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        while (m_inp) step(0, 1'b0);
        rk = $urandom_range(0, 31); rl = $urandom_range(0, 31); rthr = $urandom_range(50, 300);
        configure(rk, rl, $urandom_range(0, 255), rthr, 1'b0);
      end
      r = $urandom_range(0, 9);
      d = (r < 4) ? DW'($urandom_range(0, rthr)) : DW'($urandom_range(0, 1023));
      step(d, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule : tb_filter_seq_ctrl
